alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle combinational integer ALU.
- Accepts one reservation-station op per cycle through a valid/ready handshake, then computes the result.
- Carries the result through DEPTH register stages into an OBUF-entry output FIFO.
- Drives the CDB from the FIFO head under a grant handshake, so results are not lost when the CDB arbiter picks another unit.
- Supports ROB flush.

---
 rtl/alu_pipe.sv | 181 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined integer ALU with credit-based input handshake and a CDB output FIFO
module alu_pipe #(
    parameter int XLEN  = 32,
    parameter int ROB_W = 4,
    parameter int OPT_W = 6,
    parameter int DEPTH = 2,
    parameter int OBUF  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPT_W-1:0] in_opt,
    input  logic [XLEN-1:0]  in_val1,
    input  logic [XLEN-1:0]  in_val2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [ROB_W-1:0] in_rob_idx,
    output logic             cdb_valid,
    output logic [ROB_W-1:0] cdb_src,
    output logic [XLEN-1:0]  cdb_val,
    output logic             cdb_tk,
    input  logic             cdb_grant
);
    localparam logic [OPT_W-1:0] OPT_LUI   = OPT_W'(1);
    localparam logic [OPT_W-1:0] OPT_AUIPC = OPT_W'(2);
    localparam logic [OPT_W-1:0] OPT_JAL   = OPT_W'(3);
    localparam logic [OPT_W-1:0] OPT_JALR  = OPT_W'(4);
    localparam logic [OPT_W-1:0] OPT_BEQ   = OPT_W'(5);
    localparam logic [OPT_W-1:0] OPT_BNE   = OPT_W'(6);
    localparam logic [OPT_W-1:0] OPT_BLT   = OPT_W'(7);
    localparam logic [OPT_W-1:0] OPT_BGE   = OPT_W'(8);
    localparam logic [OPT_W-1:0] OPT_BLTU  = OPT_W'(9);
    localparam logic [OPT_W-1:0] OPT_BGEU  = OPT_W'(10);
    localparam logic [OPT_W-1:0] OPT_ADDI  = OPT_W'(19);
    localparam logic [OPT_W-1:0] OPT_SLTI  = OPT_W'(20);
    localparam logic [OPT_W-1:0] OPT_SLTIU = OPT_W'(21);
    localparam logic [OPT_W-1:0] OPT_XORI  = OPT_W'(22);
    localparam logic [OPT_W-1:0] OPT_ORI   = OPT_W'(23);
    localparam logic [OPT_W-1:0] OPT_ANDI  = OPT_W'(24);
    localparam logic [OPT_W-1:0] OPT_SLLI  = OPT_W'(25);
    localparam logic [OPT_W-1:0] OPT_SRLI  = OPT_W'(26);
    localparam logic [OPT_W-1:0] OPT_SRAI  = OPT_W'(27);
    localparam logic [OPT_W-1:0] OPT_ADD   = OPT_W'(28);
    localparam logic [OPT_W-1:0] OPT_SUB   = OPT_W'(29);
    localparam logic [OPT_W-1:0] OPT_SLL   = OPT_W'(30);
    localparam logic [OPT_W-1:0] OPT_SLT   = OPT_W'(31);
    localparam logic [OPT_W-1:0] OPT_SLTU  = OPT_W'(32);
    localparam logic [OPT_W-1:0] OPT_XOR   = OPT_W'(33);
    localparam logic [OPT_W-1:0] OPT_SRL   = OPT_W'(34);
    localparam logic [OPT_W-1:0] OPT_SRA   = OPT_W'(35);
    localparam logic [OPT_W-1:0] OPT_OR    = OPT_W'(36);
    localparam logic [OPT_W-1:0] OPT_AND   = OPT_W'(37);

    localparam int SW = $clog2(XLEN);
    localparam int PW = OBUF > 1 ? $clog2(OBUF) : 1;

    logic [XLEN-1:0]  res;
    logic             tk;
    logic             fire, nv, pop, tv, tt;
    logic [ROB_W-1:0] ts;
    logic [XLEN-1:0]  td;
    logic [3:0]       inflight, count;
    logic [PW-1:0]    head, tail;
    logic [ROB_W-1:0] f_src [OBUF];
    logic [XLEN-1:0]  f_val [OBUF];
    logic             f_tk  [OBUF];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(OBUF - 1)) ? '0 : p + 1'b1;
    endfunction

    // Combinational ALU on the incoming op; unknown opcodes yield zero
    always_comb begin
        res = '0;
        tk  = 1'b0;
        case (in_opt)
            OPT_LUI, OPT_AUIPC, OPT_JALR, OPT_ADDI: res = in_val1 + in_imm;
            OPT_JAL, OPT_ADD: res = in_val1 + in_val2;
            OPT_SUB:   res = in_val1 - in_val2;
            OPT_AND:   res = in_val1 & in_val2;
            OPT_OR:    res = in_val1 | in_val2;
            OPT_XOR:   res = in_val1 ^ in_val2;
            OPT_ANDI:  res = in_val1 & in_imm;
            OPT_ORI:   res = in_val1 | in_imm;
            OPT_XORI:  res = in_val1 ^ in_imm;
            OPT_SLL:   res = in_val1 << in_val2[SW-1:0];
            OPT_SRL:   res = in_val1 >> in_val2[SW-1:0];
            OPT_SRA:   res = XLEN'($signed(in_val1) >>> in_val2[SW-1:0]);
            OPT_SLLI:  res = in_val1 << in_imm[SW-1:0];
            OPT_SRLI:  res = in_val1 >> in_imm[SW-1:0];
            OPT_SRAI:  res = XLEN'($signed(in_val1) >>> in_imm[SW-1:0]);
            OPT_SLT:   res = XLEN'($signed(in_val1) < $signed(in_val2));
            OPT_SLTI:  res = XLEN'($signed(in_val1) < $signed(in_imm));
            OPT_SLTU:  res = XLEN'(in_val1 < in_val2);
            OPT_SLTIU: res = XLEN'(in_val1 < in_imm);
            OPT_BEQ:   tk  = in_val1 == in_val2;
            OPT_BNE:   tk  = in_val1 != in_val2;
            OPT_BLT:   tk  = $signed(in_val1) < $signed(in_val2);
            OPT_BGE:   tk  = $signed(in_val1) >= $signed(in_val2);
            OPT_BLTU:  tk  = in_val1 < in_val2;
            OPT_BGEU:  tk  = in_val1 >= in_val2;
            default: ;
        endcase
    end

    // A pop frees its credit in the same cycle, so in_ready depends on the grant
    assign cdb_valid = rdy & ~rst & (count != 4'd0);
    assign pop       = cdb_valid & cdb_grant;
    assign in_ready  = rdy & ~rst & ((inflight + count - {3'b0, pop}) < 4'(OBUF));
    assign fire      = in_valid & in_ready & ~flush;
    assign nv        = fire & (in_rob_idx != '0);
    assign cdb_src   = cdb_valid ? f_src[head] : '0;
    assign cdb_val   = cdb_valid ? f_val[head] : '0;
    assign cdb_tk    = cdb_valid & f_tk[head];

    if (DEPTH == 1) begin : g_direct
        assign tv       = nv;
        assign ts       = in_rob_idx;
        assign td       = res;
        assign tt       = tk;
        assign inflight = '0;
    end else begin : g_pipe
        localparam int NS = DEPTH - 1;
        logic             sv [NS];
        logic [ROB_W-1:0] ss [NS];
        logic [XLEN-1:0]  sd [NS];
        logic             st [NS];
        // Shift register of results ahead of the FIFO; flush kills every stage
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < NS; i++) sv[i] <= 1'b0;
            end else if (rdy) begin
                sv[0] <= nv & ~flush;
                ss[0] <= in_rob_idx;
                sd[0] <= res;
                st[0] <= tk;
                for (int i = 1; i < NS; i++) begin
                    sv[i] <= sv[i-1] & ~flush;
                    ss[i] <= ss[i-1];
                    sd[i] <= sd[i-1];
                    st[i] <= st[i-1];
                end
            end
        end
        // Count occupied stages for the credit check
        always_comb begin
            inflight = '0;
            for (int i = 0; i < NS; i++) inflight = inflight + {3'b0, sv[i]};
        end
        assign tv = sv[NS-1];
        assign ts = ss[NS-1];
        assign td = sd[NS-1];
        assign tt = st[NS-1];
    end

    // Circular output FIFO; credits guarantee a push never meets a full buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (tv) begin
                    f_src[tail] <= ts;
                    f_val[tail] <= td;
                    f_tk[tail]  <= tt;
                    tail        <= nxt(tail);
                end
                if (pop) head <= nxt(head);
                count <= count + {3'b0, tv} - {3'b0, pop};
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed-vector bench for alu_pipe (DEPTH=2, OBUF=2)
module tb_alu_pipe;
    localparam logic [5:0] LUI = 1, BEQ = 5, BNE = 6, BLT = 7, BGEU = 10, SLTI = 20, SRAI = 27;
    localparam logic [5:0] ADD = 28, SUB = 29, SLL = 30, SLTU = 32, XOR = 33, AND = 37, UNK = 12;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a, b, im;
        logic [3:0]  rob;
        logic [31:0] ev;
        logic        et;
    } vec_t;

    logic        clk = 0, rst = 1, rdy = 1, flush = 0, in_valid = 0, cdb_grant = 1;
    logic [5:0]  in_opt = '0;
    logic [31:0] in_val1 = '0, in_val2 = '0, in_imm = '0;
    logic [3:0]  in_rob_idx = '0;
    logic        in_ready, cdb_valid, cdb_tk;
    logic [3:0]  cdb_src;
    logic [31:0] cdb_val;
    int          n_vec = 0, n_err = 0;
    vec_t        vt [12];

    alu_pipe #(.XLEN(32), .ROB_W(4), .OPT_W(6), .DEPTH(2), .OBUF(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opt(in_opt),
        .in_val1(in_val1), .in_val2(in_val2), .in_imm(in_imm), .in_rob_idx(in_rob_idx),
        .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_val(cdb_val), .cdb_tk(cdb_tk),
        .cdb_grant(cdb_grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [3:0] rob);
        in_valid = v; in_opt = op; in_val1 = a; in_val2 = b; in_imm = im; in_rob_idx = rob;
    endtask

    task automatic expect_cdb(input string tag, input logic v, input logic [3:0] s, input logic [31:0] d, input logic t);
        chk({tag, "_valid"}, 32'(cdb_valid), 32'(v));
        chk({tag, "_src"}, 32'(cdb_src), 32'(s));
        chk({tag, "_val"}, cdb_val, d);
        chk({tag, "_tk"}, 32'(cdb_tk), 32'(t));
    endtask

    initial begin
        vt[0]  = '{SUB,  32'h1,        32'h2,        32'h0,        4'd1,  32'hFFFFFFFF, 1'b0};
        vt[1]  = '{SRAI, 32'h80000000, 32'h0,        32'h4,        4'd2,  32'hF8000000, 1'b0};
        vt[2]  = '{BLT,  32'hFFFFFFFF, 32'h1,        32'h0,        4'd4,  32'h0,        1'b1};
        vt[3]  = '{SLTU, 32'h1,        32'hFFFFFFFF, 32'h0,        4'd5,  32'h1,        1'b0};
        vt[4]  = '{AND,  32'hF0F0,     32'hFF00,     32'h0,        4'd6,  32'hF000,     1'b0};
        vt[5]  = '{SLL,  32'h1,        32'd33,       32'h0,        4'd7,  32'h2,        1'b0};
        vt[6]  = '{BGEU, 32'h1,        32'hFFFFFFFF, 32'h0,        4'd8,  32'h0,        1'b0};
        vt[7]  = '{UNK,  32'h5,        32'h5,        32'h5,        4'd9,  32'h0,        1'b0};
        vt[8]  = '{LUI,  32'h0,        32'h0,        32'h12345000, 4'd10, 32'h12345000, 1'b0};
        vt[9]  = '{SLTI, 32'hFFFFFFFB, 32'h0,        32'h3,        4'd11, 32'h1,        1'b0};
        vt[10] = '{BNE,  32'h3,        32'h3,        32'h0,        4'd12, 32'h0,        1'b0};
        vt[11] = '{BEQ,  32'h7,        32'h7,        32'h0,        4'd13, 32'h0,        1'b1};

        tick;
        #1;
        chk("rst_ready", 32'(in_ready), 0);
        expect_cdb("rst_cdb", 0, 0, 0, 0);
        tick;
        rst = 0;

        drive(1, ADD, 5, 7, 0, 3);
        #1 chk("add_ready", 32'(in_ready), 1);
        tick;
        drive(0, ADD, 0, 0, 0, 0);
        #1 chk("add_c1_valid", 32'(cdb_valid), 0);
        tick;
        #1 expect_cdb("add_c2", 1, 3, 12, 0);
        tick;
        #1 chk("add_c3_valid", 32'(cdb_valid), 0);

        for (int i = 0; i < 14; i++) begin
            if (i < 12) drive(1, vt[i].op, vt[i].a, vt[i].b, vt[i].im, vt[i].rob);
            else drive(0, ADD, 0, 0, 0, 0);
            #1;
            if (i < 12) chk("b2b_ready", 32'(in_ready), 1);
            if (i >= 2) expect_cdb("b2b", 1, vt[i-2].rob, vt[i-2].ev, vt[i-2].et);
            tick;
        end
        #1 chk("b2b_drained", 32'(cdb_valid), 0);

        cdb_grant = 0;
        drive(1, ADD, 1, 1, 0, 1);
        #1 chk("bp_ready0", 32'(in_ready), 1);
        tick;
        drive(1, ADD, 2, 2, 0, 2);
        #1 chk("bp_ready1", 32'(in_ready), 1);
        tick;
        drive(1, ADD, 3, 3, 0, 3);
        #1 chk("bp_ready2", 32'(in_ready), 0);
        tick;
        #1 chk("bp_ready3", 32'(in_ready), 0);
        expect_cdb("bp_head3", 1, 1, 2, 0);
        tick;
        drive(0, ADD, 0, 0, 0, 0);
        cdb_grant = 1;
        #1 chk("bp_pop_ready", 32'(in_ready), 1);
        expect_cdb("bp_pop", 1, 1, 2, 0);
        tick;
        cdb_grant = 0;
        #1 expect_cdb("bp_next", 1, 2, 4, 0);
        tick;
        cdb_grant = 1;
        tick;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_no_third", 32'(cdb_valid), 0);
            tick;
        end

        cdb_grant = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, ADD, 9, 9, 0, 0);
            #1 chk("rob0_ready", 32'(in_ready), 1);
            chk("rob0_valid", 32'(cdb_valid), 0);
            tick;
        end
        drive(0, ADD, 0, 0, 0, 0);
        #1 chk("rob0_after", 32'(cdb_valid), 0);

        drive(1, ADD, 1, 1, 0, 1);
        tick;
        drive(1, ADD, 2, 2, 0, 2);
        tick;
        drive(1, ADD, 3, 3, 0, 3);
        flush = 1;
        cdb_grant = 1;
        #1 chk("fl_head", 32'(cdb_valid), 1);
        tick;
        flush = 0;
        drive(0, ADD, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            #1 chk("fl_empty", 32'(cdb_valid), 0);
            tick;
        end
        drive(1, SUB, 10, 3, 0, 7);
        #1 chk("fl_new_ready", 32'(in_ready), 1);
        tick;
        drive(0, ADD, 0, 0, 0, 0);
        #1 chk("fl_new_c1", 32'(cdb_valid), 0);
        tick;
        #1 expect_cdb("fl_new_c2", 1, 7, 7, 0);
        tick;
        #1 chk("fl_new_c3", 32'(cdb_valid), 0);

        drive(1, XOR, 32'hFF, 32'h0F, 0, 5);
        tick;
        drive(0, ADD, 0, 0, 0, 0);
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_valid", 32'(cdb_valid), 0);
            chk("stall_ready", 32'(in_ready), 0);
            tick;
        end
        rdy = 1;
        #1 chk("stall_resume0", 32'(cdb_valid), 0);
        tick;
        #1 expect_cdb("stall_resume1", 1, 5, 32'hF0, 0);
        tick;

        cdb_grant = 0;
        drive(1, ADD, 4, 4, 0, 1);
        tick;
        drive(1, ADD, 6, 6, 0, 2);
        tick;
        drive(0, ADD, 0, 0, 0, 0);
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            #1 chk("mrst_ready", 32'(in_ready), 0);
            expect_cdb("mrst_cdb", 0, 0, 0, 0);
            tick;
        end
        rst = 0;
        cdb_grant = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("mrst_stale", 32'(cdb_valid), 0);
            chk("mrst_ready_after", 32'(in_ready), 1);
            tick;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
